// File: rtl/mem_arbiter.sv
// Purpose : single-port RAM front end shared by instruction fetch and data
//           load/store of a multi-cycle processor.
// Latency : read 3 cycles from request to ivalid/dvalid; write 2 cycles from
//           accept until Run returns high.
// Backpressure: Run is held low while an access is in flight. Requests seen
//           outside an arbitration cycle are ignored, not queued. The
//           processor keeps a request asserted until it is served.
//
// Ports:
//   Clock, Resetn      clock; asynchronous active-high reset (historical name)
//   fetch_req, pc      instruction fetch request and word address
//   ld_req, addtomem   data load request and address (low ADDR_W bits used)
//   datatomem, WriteEn store data and store strobe (only WriteEn[0] matters)
//   DIN, ivalid        last fetched instruction word and its 1-cycle update pulse
//   memin, dvalid      last loaded data word and its 1-cycle update pulse
//   Run                processor enable, low while an access is pending
//   ram_addr/ram_wdata/ram_we/ram_rdata   synchronous single-port RAM
//                      (read data valid one cycle after the address)
//
// Optional feature macro: MEM_ARB_PREFETCH_EN. When defined, a one-entry
// instruction prefetch buffer is added. After a fetch completes, the buffer
// holds the next sequential word so that a following fetch of that word
// completes without dropping Run.
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              fetch_req,
  input  logic [5:0]        pc,
  input  logic              ld_req,
  input  logic [DATA_W-1:0] addtomem,
  input  logic [DATA_W-1:0] datatomem,
  input  logic [15:0]       WriteEn,
  output logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] memin,
  output logic              ivalid,
  output logic              dvalid,
  output logic              Run,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, RD_ADDR, RD_DATA} state_t;
  // K_PREF marks a speculative instruction read. It is used only when the
  // prefetch buffer is built in.
  typedef enum logic [1:0] {K_INSTR, K_DATA, K_PREF} kind_t;

  state_t state;
  kind_t  kind;

  // Word addresses: pc and addtomem are zero-extended or truncated to ADDR_W.
  logic [ADDR_W-1:0] pc_a;
  logic [ADDR_W-1:0] ld_a;
  assign pc_a = ADDR_W'(pc);
  assign ld_a = ADDR_W'(addtomem);

  // The upper strobe bits carry no meaning. The address high bits are
  // dropped by the truncation above.
  logic unused_bits;
  assign unused_bits = ^{WriteEn[15:1], addtomem};

`ifdef MEM_ARB_PREFETCH_EN
  logic [ADDR_W-1:0] pf_addr;   // address held (or being filled) by the buffer
  logic [DATA_W-1:0] pf_data;
  logic              pf_valid;
  logic              pf_trig;   // a fetch finished; prefetch pf_next when free
  logic [ADDR_W-1:0] pf_next;
  logic              pf_hit;
  logic              acc_hit;
  logic              acc_pf;
  logic [DATA_W-1:0] hit_data;
`endif

  // Arbitration decision for this cycle. Priority is write, then load, then
  // fetch. Losing requests are simply not accepted.
  logic arb_en;
  logic acc_wr;
  logic acc_ld;
  logic acc_fe;

  always_comb begin
    arb_en = (state == IDLE);
`ifdef MEM_ARB_PREFETCH_EN
    // The last cycle of a speculative read also arbitrates. A real request
    // that arrives during a prefetch therefore waits at most one cycle.
    if (state == RD_DATA && kind == K_PREF) arb_en = 1'b1;
`endif
    acc_wr = arb_en && WriteEn[0];
    acc_ld = arb_en && !WriteEn[0] && ld_req;
    acc_fe = arb_en && !WriteEn[0] && !ld_req && fetch_req;
`ifdef MEM_ARB_PREFETCH_EN
    // In IDLE the hit comes from the buffer. At the end of a speculative
    // read, the word is still on ram_rdata and is forwarded directly.
    if (state == IDLE) begin
      pf_hit   = pf_valid && (pc_a == pf_addr);
      hit_data = pf_data;
    end else begin
      pf_hit   = (pc_a == pf_addr);
      hit_data = ram_rdata;
    end
    acc_hit = acc_fe && pf_hit;
    acc_fe  = acc_fe && !pf_hit;
    acc_pf  = arb_en && !WriteEn[0] && !ld_req && !fetch_req && pf_trig;
`endif
  end

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      state     <= IDLE;
      kind      <= K_INSTR;
      DIN       <= '0;
      memin     <= '0;
      ivalid    <= 1'b0;
      dvalid    <= 1'b0;
      Run       <= 1'b1;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
`ifdef MEM_ARB_PREFETCH_EN
      pf_addr   <= '0;
      pf_data   <= '0;
      pf_valid  <= 1'b0;
      pf_trig   <= 1'b0;
      pf_next   <= '0;
`endif
    end else begin
      ivalid <= 1'b0;
      dvalid <= 1'b0;
      ram_we <= 1'b0;

      case (state)
        WRITE: begin
          state <= IDLE;
          Run   <= 1'b1;
        end
        RD_ADDR: begin
          state <= RD_DATA;
        end
        RD_DATA: begin
          case (kind)
            K_INSTR: begin
              DIN    <= ram_rdata;
              ivalid <= 1'b1;
`ifdef MEM_ARB_PREFETCH_EN
              // ram_addr still holds the fetched address. The increment wraps
              // naturally, so the word after the last address is address 0.
              pf_trig <= 1'b1;
              pf_next <= ram_addr + ADDR_W'(1);
`endif
            end
            K_DATA: begin
              memin  <= ram_rdata;
              dvalid <= 1'b1;
            end
            default: begin
`ifdef MEM_ARB_PREFETCH_EN
              // Set here, then cleared below if a write to pf_addr or a
              // forwarded hit occurs in this same cycle.
              pf_data  <= ram_rdata;
              pf_valid <= 1'b1;
`endif
            end
          endcase
          state <= IDLE;
          Run   <= 1'b1;
        end
        default: begin
        end
      endcase

      // Acceptance comes after the per-state updates. Its assignments take
      // precedence when the RD_DATA cycle of a prefetch also arbitrates.
      if (acc_wr) begin
        state     <= WRITE;
        ram_we    <= 1'b1;
        ram_addr  <= ld_a;
        ram_wdata <= datatomem;
        Run       <= 1'b0;
`ifdef MEM_ARB_PREFETCH_EN
        if (ld_a == pf_addr) pf_valid <= 1'b0;
`endif
      end else if (acc_ld) begin
        state    <= RD_ADDR;
        kind     <= K_DATA;
        ram_addr <= ld_a;
        Run      <= 1'b0;
      end else if (acc_fe) begin
        state    <= RD_ADDR;
        kind     <= K_INSTR;
        ram_addr <= pc_a;
        Run      <= 1'b0;
      end
`ifdef MEM_ARB_PREFETCH_EN
      else if (acc_hit) begin
        // Served without touching the RAM. Consume the entry and queue the
        // next sequential prefetch.
        DIN      <= hit_data;
        ivalid   <= 1'b1;
        pf_valid <= 1'b0;
        pf_trig  <= 1'b1;
        pf_next  <= pc_a + ADDR_W'(1);
      end else if (acc_pf) begin
        // A speculative read keeps Run high. The processor is never stalled
        // by it.
        state    <= RD_ADDR;
        kind     <= K_PREF;
        ram_addr <= pf_next;
        pf_addr  <= pf_next;
        pf_valid <= 1'b0;
        pf_trig  <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;

  localparam logic [1:0] OP_WR   = 2'd0;
  localparam logic [1:0] OP_LD   = 2'd1;
  localparam logic [1:0] OP_FE   = 2'd2;
  localparam logic [1:0] OP_JUNK = 2'd3;  // strobe with bit 0 clear, no requests

  logic              Clock = 1'b0;
  logic              Resetn = 1'b1;
  logic              fetch_req = 1'b0;
  logic [5:0]        pc = '0;
  logic              ld_req = 1'b0;
  logic [DATA_W-1:0] addtomem = '0;
  logic [DATA_W-1:0] datatomem = '0;
  logic [15:0]       WriteEn = '0;
  logic [DATA_W-1:0] DIN;
  logic [DATA_W-1:0] memin;
  logic              ivalid;
  logic              dvalid;
  logic              Run;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [15:0] iq[$];
  logic [15:0] dq[$];

  always #5 Clock = ~Clock;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clock(Clock), .Resetn(Resetn), .fetch_req(fetch_req), .pc(pc),
    .ld_req(ld_req), .addtomem(addtomem), .datatomem(datatomem),
    .WriteEn(WriteEn), .DIN(DIN), .memin(memin), .ivalid(ivalid),
    .dvalid(dvalid), .Run(Run), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  // Synchronous RAM model. Unwritten words read as A000|addr, except word 5.
  logic [15:0] mem [64];
  logic [63:0] wr_mask = '0;

  function automatic logic [15:0] init_word(input logic [5:0] a);
    return (a == 6'd5) ? 16'h1234 : {10'b1010_0000_00, a};
  endfunction

  always @(posedge Clock) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      wr_mask[ram_addr] <= 1'b1;
    end
    ram_rdata <= wr_mask[ram_addr] ? mem[ram_addr] : init_word(ram_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each valid pulse must match the oldest expected word.
  always @(negedge Clock) begin
    if (Resetn === 1'b0) begin
      if (ivalid === 1'b1) begin
        if (iq.size() == 0) begin
          checks++; errors++;
          $display("FAIL ivalid_unexpected: got DIN=%0h expected no pulse", DIN);
        end else chk("DIN", DIN, iq.pop_front());
      end
      if (dvalid === 1'b1) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL dvalid_unexpected: got memin=%0h expected no pulse", memin);
        end else chk("memin", memin, dq.pop_front());
      end
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    logic [5:0]  exp_addr;
    logic [15:0] exp_data;
    int          exp_low;   // cycles Run stays low
  } vec_t;

  task automatic idle(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Caller is at posedge+1 with the DUT idle. Returns at posedge+1.
  task automatic do_op(input string tag, input vec_t v);
    int low;
    logic saw_we, got_valid;
    logic [5:0] seen_addr;
    logic [15:0] seen_wd;
    case (v.op)
      OP_WR:   begin WriteEn = 16'h0001; addtomem = v.addr; datatomem = v.data; end
      OP_LD:   begin ld_req = 1'b1; addtomem = v.addr; dq.push_back(v.exp_data); end
      OP_FE:   begin fetch_req = 1'b1; pc = v.addr[5:0]; iq.push_back(v.exp_data); end
      default: begin WriteEn = 16'hFFFE; addtomem = v.addr; datatomem = v.data; end
    endcase
    low = 0; saw_we = 1'b0; got_valid = 1'b0; seen_addr = '0; seen_wd = '0;
    for (int c = 0; c < 10; c++) begin
      @(posedge Clock); #1;
      if (c == 0) begin
        WriteEn = '0; ld_req = 1'b0; fetch_req = 1'b0;
        seen_addr = ram_addr; seen_wd = ram_wdata;
      end
      if (ram_we) saw_we = 1'b1;
      if (Run) begin
        got_valid = ivalid | dvalid;
        break;
      end
      low++;
    end
    chk({tag, "_run_low"}, low, v.exp_low);
    chk({tag, "_ram_we"}, saw_we, (v.op == OP_WR));
    if (v.exp_low > 0) chk({tag, "_ram_addr"}, seen_addr, v.exp_addr);
    if (v.op == OP_WR) chk({tag, "_ram_wdata"}, seen_wd, v.data);
    if (v.op == OP_LD || v.op == OP_FE) chk({tag, "_valid"}, got_valid, 1'b1);
    if (v.op == OP_JUNK) chk({tag, "_no_valid"}, got_valid, 1'b0);
    idle(4);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    vec_t v;
    int order[3];
    int n;
    logic prev_run;

    tbl[0] = '{OP_FE,   16'h0005, 16'h0000, 6'd5,  16'h1234, 2};
    tbl[1] = '{OP_WR,   16'h0009, 16'hBEEF, 6'd9,  16'h0000, 1};
    tbl[2] = '{OP_LD,   16'h0009, 16'h0000, 6'd9,  16'hBEEF, 2};
    tbl[3] = '{OP_LD,   16'h0047, 16'h0000, 6'd7,  16'hA007, 2};
    tbl[4] = '{OP_JUNK, 16'h0009, 16'h0000, 6'd9,  16'h0000, 0};
    tbl[5] = '{OP_LD,   16'h0009, 16'h0000, 6'd9,  16'hBEEF, 2};
    tbl[6] = '{OP_FE,   16'h003F, 16'h0000, 6'd63, 16'hA03F, 2};
    tbl[7] = '{OP_WR,   16'hFFC3, 16'h1111, 6'd3,  16'h0000, 1};
    tbl[8] = '{OP_FE,   16'h0003, 16'h0000, 6'd3,  16'h1111, 2};
    tbl[9] = '{OP_LD,   16'h0123, 16'h0000, 6'd35, 16'hA023, 2};

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_Run", Run, 1'b1);
    chk("rst_DIN", DIN, 16'h0);
    chk("rst_memin", memin, 16'h0);
    chk("rst_ivalid", ivalid, 1'b0);
    chk("rst_dvalid", dvalid, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, 6'd0);
    chk("rst_ram_wdata", ram_wdata, 16'h0);
    Resetn = 1'b0;
    idle(2);

    for (int i = 0; i < 10; i++) do_op($sformatf("vec%0d", i), tbl[i]);

    // Priority: all three requests held until each is accepted.
    WriteEn = 16'h0001; addtomem = 16'd12; datatomem = 16'hCAFE;
    ld_req = 1'b1; fetch_req = 1'b1; pc = 6'd20;
    dq.push_back(16'hCAFE);
    iq.push_back(16'hA014);
    n = 0; prev_run = 1'b1;
    order[0] = 0; order[1] = 0; order[2] = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge Clock); #1;
      if (prev_run && !Run) begin
        if (ram_we) begin
          WriteEn = '0; if (n < 3) order[n] = 1;
        end else if (ram_addr == 6'd12) begin
          ld_req = 1'b0; if (n < 3) order[n] = 2;
        end else if (ram_addr == 6'd20) begin
          fetch_req = 1'b0; if (n < 3) order[n] = 3;
        end else if (n < 3) order[n] = 9;
        n++;
      end
      prev_run = Run;
      if (n >= 3 && Run) break;
    end
    WriteEn = '0; ld_req = 1'b0; fetch_req = 1'b0;
    chk("prio_count", n, 3);
    chk("prio_first_write", order[0], 1);
    chk("prio_second_load", order[1], 2);
    chk("prio_third_fetch", order[2], 3);
    idle(4);

    // Reset during RD_ADDR aborts the fetch.
    fetch_req = 1'b1; pc = 6'd10;
    @(posedge Clock); #1;
    fetch_req = 1'b0;
    chk("rdrst_Run_low", Run, 1'b0);
    chk("rdrst_ram_addr", ram_addr, 6'd10);
    #2 Resetn = 1'b1;
    #1;
    chk("rdrst_Run", Run, 1'b1);
    chk("rdrst_DIN", DIN, 16'h0);
    chk("rdrst_memin", memin, 16'h0);
    chk("rdrst_ivalid", ivalid, 1'b0);
    @(posedge Clock); #1;
    Resetn = 1'b0;
    idle(4);
    chk("rdrst_Run_after", Run, 1'b1);

    // Reset during WRITE: the store must not land.
    WriteEn = 16'h0001; addtomem = 16'd9; datatomem = 16'h9999;
    @(posedge Clock); #1;
    WriteEn = '0;
    chk("wrrst_we_before", ram_we, 1'b1);
    #2 Resetn = 1'b1;
    #1;
    chk("wrrst_we_after", ram_we, 1'b0);
    @(posedge Clock); #1;
    Resetn = 1'b0;
    idle(2);
    v = '{OP_LD, 16'h0009, 16'h0000, 6'd9, 16'hBEEF, 2};
    do_op("wrrst_load", v);

`ifdef MEM_ARB_PREFETCH_EN
    v = '{OP_FE, 16'h003F, 16'h0000, 6'd63, 16'hA03F, 2};
    do_op("pf_fetch63", v);
    v = '{OP_FE, 16'h0000, 16'h0000, 6'd0, 16'hA000, 0};
    do_op("pf_hit0", v);
    v = '{OP_FE, 16'h003F, 16'h0000, 6'd63, 16'hA03F, 2};
    do_op("pf_fetch63b", v);
    v = '{OP_WR, 16'h0000, 16'h7777, 6'd0, 16'h0000, 1};
    do_op("pf_store0", v);
    v = '{OP_FE, 16'h0000, 16'h0000, 6'd0, 16'h7777, 2};
    do_op("pf_miss0", v);
`endif

    idle(2);
    chk("iq_drained", iq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory front end directly downstream of the multi-cycle processor.
- Shares one synchronous single-port RAM between instruction fetch (pc) and data load/store (addtomem/datatomem/WriteEn).
- Returns instruction words on DIN and load data on memin.
- Holds the processor via Run while an access is in flight.

Parameters:
- ADDR_W, 6, RAM word-address width; pc and addtomem are zero-extended or truncated to ADDR_W low bits.
- DATA_W, 16, data word width.

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- Resetn  input  1  asynchronous, active-high reset (the name is historical; asserting it high resets the block).
- fetch_req  input  1  instruction fetch request; samples pc.
- pc  input  6  instruction word address.
- ld_req  input  1  data read request; samples addtomem.
- addtomem  input  DATA_W  data address.
- datatomem  input  DATA_W  store data.
- WriteEn  input  16  store strobe; only bit 0 is used, bits 15:1 are ignored.
- DIN  output  DATA_W  last fetched instruction word.
- memin  output  DATA_W  last loaded data word.
- ivalid  output  1  one-cycle pulse: DIN was updated this cycle.
- dvalid  output  1  one-cycle pulse: memin was updated this cycle.
- Run  output  1  processor enable; low while an access is pending.
- ram_addr  output  ADDR_W  RAM address.
- ram_wdata  output  DATA_W  RAM write data.
- ram_we  output  1  RAM write enable.
- ram_rdata  input  DATA_W  RAM read data, valid one cycle after the address is presented.

Behaviour:
- Reset values: state=IDLE; DIN, memin, ram_addr, ram_wdata = 0; ivalid, dvalid, ram_we = 0; Run=1.
- Reset mid-access aborts immediately. The RAM write is not issued if reset is asserted in the WRITE cycle.
- FSM states: IDLE, WRITE, RD_ADDR, RD_DATA. Read kind is tracked in a register (kind = INSTR/DATA).
- IDLE acceptance priority when several requests are high in the same cycle:
  - WriteEn[0] first → WRITE.
  - else ld_req → RD_ADDR with kind=DATA.
  - else fetch_req → RD_ADDR with kind=INSTR.
  - Requests that lose arbitration are not queued; the processor must hold them until served.
- Acceptance cycle: the address is latched (pc or addtomem[ADDR_W-1:0]) and Run drops to 0 in the next cycle.
- WRITE (1 cycle):
  - ram_we=1, ram_addr=latched address, ram_wdata=latched datatomem.
  - Next state IDLE; Run=1 again the following cycle.
- RD_ADDR (1 cycle): ram_addr driven, ram_we=0; next state RD_DATA.
- RD_DATA:
  - ram_rdata is captured into DIN (kind=INSTR) or memin (kind=DATA).
  - The matching valid pulses high for exactly 1 cycle; next state IDLE.
  - DIN and memin hold their values until the next capture of the same kind.
- Latency, request to valid: 3 cycles (accept, RD_ADDR, RD_DATA).
- Latency, write: 2 cycles from accept to Run=1.
- Run timing: Run=0 from the cycle after acceptance up to and including the RD_DATA/WRITE cycle; Run=1 in IDLE.
- Requests arriving while not in IDLE are ignored. They are re-evaluated only in IDLE.
- Address wrap: pc=63 with ADDR_W=6 reads address 63. There is no increment here, so no wrap logic is needed in the base block.
- Store followed by load to the same address: the load observes the new data. Ordering is guaranteed because the write completes before IDLE.

Optional Feature:
- Macro MEM_ARB_PREFETCH_EN.
- Defined: adds a one-entry prefetch buffer (pf_addr, pf_data, pf_valid).
  - After any instruction fetch completes, if no request is pending in IDLE, the FSM speculatively reads (last pc + 1) mod 2^ADDR_W and fills the buffer.
  - A fetch_req with pc == pf_addr while pf_valid=1 is served from the buffer: DIN=pf_data and ivalid in the cycle after the request, with no Run drop. pf_valid then clears and a new prefetch starts.
  - Any write to pf_addr clears pf_valid.
  - A real request arriving during a speculative read waits until the speculative read finishes (at most 1 extra cycle) and takes priority over further prefetch.
  - pc=63 prefetches address 0.
- Undefined: no buffer, and behaviour is exactly as described in Behaviour.

Test Plan:
- Reset: Resetn=1 mid-RD_ADDR → next edge state=IDLE, Run=1, DIN=0, memin=0, ivalid=0.
- Fetch: RAM[5]=16'h1234, fetch_req=1, pc=5 → ivalid pulses 3 cycles later, DIN=16'h1234, Run low for exactly 2 cycles.
- Store then load: WriteEn=16'h0001, addtomem=9, datatomem=16'hBEEF; then ld_req, addtomem=9 → ram_we 1 cycle, memin=16'hBEEF, dvalid 1 cycle.
- Priority: WriteEn[0], ld_req and fetch_req all high in IDLE → write served first, then load, then fetch, each with a full handshake.
- Address truncation: ld_req with addtomem=16'h0047, ADDR_W=6 → ram_addr=7.
- MEM_ARB_PREFETCH_EN defined: fetch pc=63, then fetch pc=0 after idle → second ivalid one cycle after request, Run stays 1, DIN=RAM[0]. Store to address 0 before that fetch → normal 3-cycle read.
